// File: rtl/button_event_pkg.sv
// Shared types and sizing helpers for the button event parser.
// Auto-repeat support is selected by the BUTTON_REPEAT_EN macro in the consuming modules.
package button_event_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      HELD   = 2'd2,
      REPEAT = 2'd3
   } btn_state_e;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_event_channel.sv
// One input channel: synchroniser, tick-driven debounce FSM and event pulses.
// BUTTON_REPEAT_EN builds the HELD->REPEAT auto-repeat path; otherwise repeat_o is constant 0.
module button_event_channel
   import button_event_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned PULSE_COUNT_MAX = 149,
   parameter int unsigned REPEAT_DELAY    = 658,
   parameter int unsigned REPEAT_PERIOD   = 132
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  logic in_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   if (SYNC_STAGES < 2 || PULSE_COUNT_MAX < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("button_event_channel: parameter out of range");
   end

`ifdef BUTTON_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned CNT_MAX = (PULSE_COUNT_MAX > REP_MAX) ? PULSE_COUNT_MAX : REP_MAX;
`else
   localparam int unsigned CNT_MAX = PULSE_COUNT_MAX;
`endif
   localparam int unsigned CW = cnt_width(CNT_MAX);
   localparam logic [CW-1:0] PRESS_LAST = CW'(PULSE_COUNT_MAX - 1);
`ifdef BUTTON_REPEAT_EN
   localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
`endif

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   btn_state_e             state_q;
   logic [CW-1:0]          cnt_q;
   logic                   level_q;
   logic                   press_q;
   logic                   release_q;
`ifdef BUTTON_REPEAT_EN
   logic                   repeat_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // State and counter only move on the shared sample tick; pulses last one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
`ifdef BUTTON_REPEAT_EN
         repeat_q  <= 1'b0;
`endif
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
`ifdef BUTTON_REPEAT_EN
         repeat_q  <= 1'b0;
`endif
         if (tick_i) begin
            case (state_q)
               IDLE: begin
                  if (s) begin
                     if (PULSE_COUNT_MAX == 1) begin
                        state_q <= HELD;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                     end else begin
                        state_q <= COUNT;
                        cnt_q   <= CW'(1);
                     end
                  end
               end
               COUNT: begin
                  if (!s) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end else if (cnt_q == PRESS_LAST) begin
                     state_q <= HELD;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               HELD: begin
                  if (!s) begin
                     state_q   <= IDLE;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                     cnt_q     <= '0;
                  end
`ifdef BUTTON_REPEAT_EN
                  else if (cnt_q == DELAY_LAST) begin
                     state_q  <= REPEAT;
                     repeat_q <= 1'b1;
                     cnt_q    <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
`endif
               end
`ifdef BUTTON_REPEAT_EN
               REPEAT: begin
                  if (!s) begin
                     state_q   <= IDLE;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                     cnt_q     <= '0;
                  end else if (cnt_q == PERIOD_LAST) begin
                     repeat_q <= 1'b1;
                     cnt_q    <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
`endif
               default: begin
                  state_q <= IDLE;
                  level_q <= 1'b0;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
`ifdef BUTTON_REPEAT_EN
   assign repeat_o  = repeat_q;
`else
   assign repeat_o  = 1'b0;
`endif

endmodule

// File: rtl/button_event_parser.sv
// Multi-channel button parser: shared sample-tick counter plus one debounce channel per input.
// Define BUTTON_REPEAT_EN to enable per-channel auto-repeat pulses.
module button_event_parser
   import button_event_pkg::*;
#(
   parameter int unsigned WIDTH            = 7,
   parameter int unsigned SYNC_STAGES      = 2,
   parameter int unsigned SAMPLE_COUNT_MAX = 38000,
   parameter int unsigned PULSE_COUNT_MAX  = 149,
   parameter int unsigned REPEAT_DELAY     = 658,
   parameter int unsigned REPEAT_PERIOD    = 132
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_i,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] press_o,
   output logic [WIDTH-1:0] release_o,
   output logic [WIDTH-1:0] repeat_o
);

   localparam int unsigned TW = cnt_width(SAMPLE_COUNT_MAX - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_COUNT_MAX - 1);

   logic [TW-1:0] tick_cnt_q;
   logic          tick;

   assign tick = (tick_cnt_q == TICK_LAST);

   always_ff @(posedge clk) begin
      if (rst)       tick_cnt_q <= '0;
      else if (tick) tick_cnt_q <= '0;
      else           tick_cnt_q <= tick_cnt_q + TW'(1);
   end

   for (genvar c = 0; c < WIDTH; c++) begin : g_chan
      button_event_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .PULSE_COUNT_MAX (PULSE_COUNT_MAX),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .tick_i    (tick),
         .in_i      (in_i[c]),
         .level_o   (level_o[c]),
         .press_o   (press_o[c]),
         .release_o (release_o[c]),
         .repeat_o  (repeat_o[c])
      );
   end

endmodule

// File: tb/tb_button_event_parser.sv
// Self-checking bench for button_event_parser with small tick/pulse counts.
// Repeat expectations follow BUTTON_REPEAT_EN.
module tb_button_event_parser;

   localparam int unsigned W = 4;

   typedef struct {
      logic [W-1:0] in;
      int           cycles;
      logic [W-1:0] press;
      logic [W-1:0] rel;
      logic [W-1:0] lvl;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in_i;
   logic [W-1:0] level_o;
   logic [W-1:0] press_o;
   logic [W-1:0] release_o;
   logic [W-1:0] repeat_o;

   always #5 clk = ~clk;

   button_event_parser #(
      .WIDTH            (W),
      .SYNC_STAGES      (2),
      .SAMPLE_COUNT_MAX (4),
      .PULSE_COUNT_MAX  (3),
      .REPEAT_DELAY     (5),
      .REPEAT_PERIOD    (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_i      (in_i),
      .level_o   (level_o),
      .press_o   (press_o),
      .release_o (release_o),
      .repeat_o  (repeat_o)
   );

   int n_vec = 0;
   int n_err = 0;
   int tot_press [W] = '{default: 0};
   int tot_rel   [W] = '{default: 0};
   int tot_rep   [W] = '{default: 0};
   int snap_p    [W] = '{default: 0};
   int snap_r    [W] = '{default: 0};
   int snap_q    [W] = '{default: 0};
   int mutex_err = 0;

   // Pulse totals per channel, plus the one-event-per-channel rule.
   always @(negedge clk) begin
      for (int c = 0; c < W; c++) begin
         if (press_o[c] === 1'b1)   tot_press[c]++;
         if (release_o[c] === 1'b1) tot_rel[c]++;
         if (repeat_o[c] === 1'b1)  tot_rep[c]++;
         if ((int'(press_o[c] === 1'b1) + int'(release_o[c] === 1'b1) + int'(repeat_o[c] === 1'b1)) > 1)
            mutex_err++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_vec++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic take_snap();
      for (int c = 0; c < W; c++) begin
         snap_p[c] = tot_press[c];
         snap_r[c] = tot_rel[c];
         snap_q[c] = tot_rep[c];
      end
   endtask

   // Pulse counts since the last snapshot, one nibble per channel.
   function automatic logic [31:0] delta(input int kind);
      logic [31:0] r;
      int          d;
      r = '0;
      for (int c = 0; c < W; c++) begin
         if (kind == 0)      d = tot_press[c] - snap_p[c];
         else if (kind == 1) d = tot_rel[c] - snap_r[c];
         else                d = tot_rep[c] - snap_q[c];
         r[4*c +: 4] = 4'(d);
      end
      return r;
   endfunction

   function automatic logic [31:0] spread(input logic [W-1:0] m);
      logic [31:0] r;
      r = '0;
      for (int c = 0; c < W; c++) r[4*c] = m[c];
      return r;
   endfunction

   vec_t vecs [7];
   vec_t sb_q [$];
   vec_t e;
   int   lat;
   int   lvl_drop;
   int   lvl_hi;
   int   n_rep;
   int   first_rep;
   logic lvl_at;
   logic [W-1:0] press_seen;

   initial begin
      vecs[0] = '{4'b0101, 30, 4'b0101, 4'b0000, 4'b0101};
      vecs[1] = '{4'b0100, 10, 4'b0000, 4'b0001, 4'b0100};
      vecs[2] = '{4'b1111, 20, 4'b1011, 4'b0000, 4'b1111};
      vecs[3] = '{4'b0110, 10, 4'b0000, 4'b1001, 4'b0110};
      vecs[4] = '{4'b0000, 10, 4'b0000, 4'b0110, 4'b0000};
      vecs[5] = '{4'b0011,  8, 4'b0000, 4'b0000, 4'b0000};
      vecs[6] = '{4'b0000, 10, 4'b0000, 4'b0000, 4'b0000};

      rst  = 1'b1;
      in_i = '0;
      step(3);
      @(negedge clk);
      check("reset level", 32'(level_o), 32'h0);
      check("reset press", 32'(press_o), 32'h0);
      check("reset release", 32'(release_o), 32'h0);
      check("reset repeat", 32'(repeat_o), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      step(2);

      // Clean press on channel 0.
      in_i = 4'b0001;
      take_snap();
      lat = -1;
      lvl_at = 1'b0;
      lvl_drop = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (press_o[0] && lat < 0) begin
            lat    = k;
            lvl_at = level_o[0];
         end
         if (lat > 0 && !level_o[0]) lvl_drop++;
      end
      @(posedge clk);
      #1;
      check_range("press latency", lat, 11, 15);
      check("level with press", 32'(lvl_at), 32'h1);
      check("level held", 32'(lvl_drop), 32'h0);
      check("single press", delta(0), spread(4'b0001));

      // Release on channel 0.
      in_i = 4'b0000;
      take_snap();
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (release_o[0] && lat < 0) lat = k;
      end
      check_range("release latency", lat, 1, 7);
      check("level after release", 32'(level_o), 32'h0);
      @(posedge clk);
      #1;
      check("release count", delta(1), spread(4'b0001));
      check("no press on release", delta(0), 32'h0);

      // Bouncing channel 1 never qualifies.
      take_snap();
      lvl_hi = 0;
      for (int i = 0; i < 200; i++) begin
         if (i % 6 == 0) in_i[1] = ~in_i[1];
         @(negedge clk);
         if (level_o[1]) lvl_hi++;
         @(posedge clk);
         #1;
      end
      in_i = '0;
      step(12);
      check("bounce press", delta(0), 32'h0);
      check("bounce level", 32'(lvl_hi), 32'h0);

      // Table vectors through the scoreboard queue.
      for (int i = 0; i < 7; i++) begin
         in_i = vecs[i].in;
         take_snap();
         sb_q.push_back(vecs[i]);
         step(vecs[i].cycles);
         e = sb_q.pop_front();
         check($sformatf("v%0d press", i), delta(0), spread(e.press));
         check($sformatf("v%0d release", i), delta(1), spread(e.rel));
         check($sformatf("v%0d level", i), 32'(level_o), 32'(e.lvl));
      end

      // Simultaneous press on all channels.
      in_i = 4'hF;
      press_seen = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (press_o != '0 && press_seen == '0) press_seen = press_o;
      end
      check("simultaneous press", 32'(press_seen), 32'hF);
      check("simultaneous level", 32'(level_o), 32'hF);

      // Reset while held: outputs clear, no release, fresh press follows.
      @(posedge clk);
      #1;
      take_snap();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid reset outputs", {level_o, press_o, release_o, repeat_o}, 32'h0);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (press_o[2] && lat < 0) lat = k;
      end
      check_range("press after reset", lat, 11, 15);
      @(posedge clk);
      #1;
      check("no release on reset", delta(1), 32'h0);

      // Auto-repeat on channel 0.
      in_i = '0;
      step(12);
      in_i = 4'b0001;
      lat = -1;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(negedge clk);
         if (press_o[0]) lat = k;
      end
      check_range("repeat test press", lat, 11, 15);
      n_rep = 0;
      first_rep = -1;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (repeat_o[0]) begin
            n_rep++;
            if (first_rep < 0) first_rep = k;
         end
      end
`ifdef BUTTON_REPEAT_EN
      check("repeat count", 32'(n_rep), 32'd8);
      check("first repeat", 32'(first_rep), 32'd20);
`else
      check("repeat count", 32'(n_rep), 32'd0);
      check("first repeat", 32'(first_rep), 32'hFFFF_FFFF);
`endif
      check("pulse exclusivity", 32'(mutex_err), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
